// File: rtl/ball_controller.sv
// ball_controller: per-frame ball motion engine for the 160x120 breakout field.
// Each accepted frame tick runs EVAL (collision flags registered from the
// current ball/paddle state) and then STEP (position/direction commit) or MISS
// (life decrement and re-park). Serve, miss and game-over sequencing live here.
//
// Handshake/pulse semantics: frame_tick is sampled only in MOVE and is never
// queued; serve is a level sampled only in IDLE. bounce and miss are
// single-cycle strobes valid in the cycle after the committing edge, and they
// coincide with the updated ball_x/ball_y/dir/lives.
module ball_controller #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 159,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 119,
    parameter int Y_PADDLE = 112,
    parameter int PADDLE_W = 16,
    parameter int X_START  = 80,
    parameter int Y_START  = 100,
    parameter int STEP     = 1,
    parameter int LIVES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [7:0] paddle_x,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       bounce,
    output logic       miss,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MOVE     = 3'd1,
        S_EVAL     = 3'd2,
        S_STEP     = 3'd3,
        S_MISS     = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    // 9-bit zero-extended constants so +STEP sums never wrap.
    localparam logic [8:0] X_MIN9   = 9'(X_MIN);
    localparam logic [8:0] X_MAX9   = 9'(X_MAX);
    localparam logic [8:0] Y_MIN9   = 9'(Y_MIN);
    localparam logic [8:0] Y_MAX9   = 9'(Y_MAX);
    localparam logic [8:0] Y_PAD9   = 9'(Y_PADDLE);
    localparam logic [8:0] PAD_W9   = 9'(PADDLE_W);
    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [7:0] STEP8    = 8'(STEP);
    localparam logic [6:0] STEP7    = 7'(STEP);
    localparam logic [7:0] X_START8 = 8'(X_START);
    localparam logic [6:0] Y_START7 = 7'(Y_START);
    localparam logic [1:0] LIVES2   = 2'(LIVES);
    localparam logic [1:0] DIR_SERVE = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] ball_x_q, ball_x_d;
    logic [6:0] ball_y_q, ball_y_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] lives_q, lives_d;
    logic       bounce_q, bounce_d;
    logic       miss_q, miss_d;
    logic       xcol_q, xcol_d;
    logic       ycol_q, ycol_d;

    logic [8:0] x9, y9, px9;
    logic       x_hit, top_hit, pad_hit, miss_hit;

    // Collision tests for the ball's next step, from current position/dir/paddle.
    always_comb begin
        x9  = {1'b0, ball_x_q};
        y9  = {2'b00, ball_y_q};
        px9 = {1'b0, paddle_x};
        x_hit    = dir_q[0] ? (x9 < X_MIN9 + STEP9) : (x9 + STEP9 > X_MAX9);
        top_hit  = dir_q[1] && (y9 < Y_MIN9 + STEP9);
        pad_hit  = !dir_q[1] && (y9 < Y_PAD9) && (y9 + STEP9 >= Y_PAD9) &&
                   (x9 >= px9) && (x9 <= px9 + PAD_W9 - 9'd1);
        miss_hit = !dir_q[1] && !pad_hit && (y9 + STEP9 > Y_MAX9);
    end

    // Next-state and register-update logic for the serve/move/eval/step/miss FSM.
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_d    = dir_q;
        lives_d  = lives_q;
        bounce_d = 1'b0;
        miss_d   = 1'b0;
        xcol_d   = xcol_q;
        ycol_d   = ycol_q;
        case (state_q)
            S_IDLE: begin
                if (serve) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (frame_tick) state_d = S_EVAL;
            end
            S_EVAL: begin
                xcol_d  = x_hit;
                ycol_d  = top_hit || pad_hit;
                state_d = miss_hit ? S_MISS : S_STEP;
            end
            S_STEP: begin
                if (!xcol_q) ball_x_d = dir_q[0] ? ball_x_q - STEP8 : ball_x_q + STEP8;
                if (!ycol_q) ball_y_d = dir_q[1] ? ball_y_q - STEP7 : ball_y_q + STEP7;
                dir_d    = dir_q ^ {ycol_q, xcol_q};
                bounce_d = xcol_q || ycol_q;
                state_d  = S_MOVE;
            end
            S_MISS: begin
                ball_x_d = X_START8;
                ball_y_d = Y_START7;
                dir_d    = DIR_SERVE;
                miss_d   = 1'b1;
                if (lives_q > 2'd1) begin
                    lives_d = lives_q - 2'd1;
                    state_d = S_IDLE;
                end else begin
                    lives_d = 2'd0;
                    state_d = S_GAMEOVER;
                end
            end
            S_GAMEOVER: begin
                state_d = S_GAMEOVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset to the serve position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ball_x_q <= X_START8;
            ball_y_q <= Y_START7;
            dir_q    <= DIR_SERVE;
            lives_q  <= LIVES2;
            bounce_q <= 1'b0;
            miss_q   <= 1'b0;
            xcol_q   <= 1'b0;
            ycol_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_q    <= dir_d;
            lives_q  <= lives_d;
            bounce_q <= bounce_d;
            miss_q   <= miss_d;
            xcol_q   <= xcol_d;
            ycol_q   <= ycol_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign dir       = dir_q;
    assign lives     = lives_q;
    assign bounce    = bounce_q;
    assign miss      = miss_q;
    assign moving    = (state_q == S_MOVE) || (state_q == S_EVAL) || (state_q == S_STEP);
    assign game_over = (state_q == S_GAMEOVER);
    assign dbg_state = state_q;

endmodule

// File: doc/ball_controller.md
# ball_controller

Frame-rate ball motion engine for the 160x120 breakout playfield. It sits directly downstream of the per-frame collision checks and upstream of the pixel drawer. On every frame tick it evaluates wall, paddle and floor contacts for the ball's next step, reflects the direction, and commits the new position. It also owns serve, miss and life-count sequencing.

## Interface
Parameters:
- X_MIN, 0, leftmost legal ball column
- X_MAX, 159, rightmost legal ball column
- Y_MIN, 0, top legal ball row
- Y_MAX, 119, bottom row; moving past it is a miss
- Y_PADDLE, 112, row the paddle occupies
- PADDLE_W, 16, paddle width in pixels
- X_START, 80, serve column
- Y_START, 100, serve row
- STEP, 1, pixels moved per axis per tick (1..7)
- LIVES, 3, lives at reset (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- frame_tick  in  1  one-cycle pulse, once per frame
- serve  in  1  level; launches the ball from IDLE
- paddle_x  in  8  leftmost paddle column
- ball_x  out  8  current ball column
- ball_y  out  7  current ball row
- dir  out  2  bit0 = 1 means x decreasing; bit1 = 1 means y decreasing (00 +x+y, 01 -x+y, 10 +x-y, 11 -x-y)
- moving  out  1  high in MOVE, EVAL, STEP
- bounce  out  1  one-cycle pulse on any reflection
- miss  out  1  one-cycle pulse on a floor miss
- lives  out  2  remaining lives
- game_over  out  1  high in GAMEOVER

## Operation
- States:
  - IDLE: ball parked at (X_START, Y_START), dir=10. serve=1 → MOVE.
  - MOVE: frame_tick=1 → EVAL.
  - EVAL: registers the collision flags from the current ball_x/ball_y/dir/paddle_x.
    - Miss flag set → MISS.
    - Otherwise → STEP.
  - STEP: commits position and dir → MOVE.
  - MISS:
    - Decrements lives and reparks the ball at start with dir=10.
    - → IDLE if the old lives > 1; otherwise → GAMEOVER with lives=0.
  - GAMEOVER: terminal; serve and frame_tick are ignored; only reset exits.
- Arithmetic: all comparisons use 9-bit zero-extended operands, so x+STEP and y+STEP never wrap. Decreasing-axis tests are x < X_MIN+STEP and y < Y_MIN+STEP, so there is no underflow.
- X collision:
  - Moving +x and x+STEP > X_MAX, or moving -x and x < X_MIN+STEP.
  - Action: flip dir[0]; x held this step.
- Top collision:
  - Moving -y and y < Y_MIN+STEP.
  - Action: flip dir[1]; y held.
- Paddle collision:
  - Requires moving +y, y < Y_PADDLE, y+STEP >= Y_PADDLE, and paddle_x <= x <= paddle_x+PADDLE_W-1 (9-bit sum).
  - Action: flip dir[1]; y held.
- Miss:
  - Moving +y, no paddle collision, and y+STEP > Y_MAX.
  - Miss has priority over an X collision in the same evaluation.
- Non-colliding axis moves by ±STEP per dir. X and Y flips in the same step (corner) both apply.
- bounce is asserted iff at least one flip was committed.

## Timing
- Reset values:
  - state=IDLE, ball_x=X_START, ball_y=Y_START, dir=10, lives=LIVES.
  - moving=0, bounce=0, miss=0, game_over=0.
  - Reset is effective immediately, including mid-EVAL/STEP or during MISS.
- Step latency:
  - frame_tick is sampled high at edge N in MOVE.
  - EVAL runs in cycle N..N+1.
  - New ball_x/ball_y/dir are visible after edge N+2, when the state is back in MOVE.
- bounce and miss:
  - bounce is high exactly during the cycle after the STEP commit edge.
  - miss is high exactly during the cycle after the MISS edge. It coincides with the updated lives and the reparked ball.
- frame_tick:
  - Pulses arriving in EVAL, STEP, MISS, IDLE or GAMEOVER are dropped, not queued.
  - frame_tick coincident with the serve transition is ignored; the first move needs a later tick.
- Input sampling: paddle_x is sampled only in EVAL; changes at other times have no effect on that step.
- moving is low in IDLE and GAMEOVER. A serve held high through MISS→IDLE relaunches one cycle after IDLE is entered.

## Test plan
- Reset, serve=1, ten frame_ticks, STEP=1 → ball_x=90, ball_y=90, dir=10, no bounce; each update appears 2 cycles after its tick.
- Preload via serve/ticks so that ball_x=159 with dir=00 at EVAL → dir=01, ball_x stays 159, ball_y+1, bounce high one cycle.
- ball_y=111, dir=00, paddle_x=80, ball_x=85 → dir=10, ball_y stays 111, bounce=1. Repeat with paddle_x=100 → no bounce; continue until ball_y=119 → next tick gives miss=1 and lives 3→2, ball at (80,100), state IDLE.
- Corner: ball_x=0, ball_y=0, dir=11 → dir=00, position unchanged, one bounce pulse.
- Three consecutive misses → lives=0, game_over=1; serve and ticks are then ignored; reset restores lives=3 and IDLE.
- Assert reset during STEP and in GAMEOVER → all outputs return to reset values asynchronously; tick pulses during EVAL are dropped (step count verified).
